// File: rtl/matmult_seq_ctrl_if.sv
// rtl/matmult_seq_ctrl_if.sv - operand load, command and result stream bundle for matmult_seq_ctrl
interface matmult_seq_ctrl_if #(
   parameter int N  = 2,
   parameter int DW = 16,
   parameter int AW = 32
);
   localparam int IW = $clog2(N*N);
   localparam int CW = $clog2(N);

   logic          load_en;
   logic          load_sel;
   logic [IW-1:0] load_addr;
   logic [DW-1:0] load_data;
   logic          start;
   logic          busy;
   logic          done;
   logic          res_valid;
   logic          res_ready;
   logic [AW-1:0] res_data;
   logic [CW-1:0] res_row;
   logic [CW-1:0] res_col;
   logic          res_last;

   modport master (
      output load_en, load_sel, load_addr, load_data, start, res_ready,
      input  busy, done, res_valid, res_data, res_row, res_col, res_last
   );

   modport slave (
      input  load_en, load_sel, load_addr, load_data, start, res_ready,
      output busy, done, res_valid, res_data, res_row, res_col, res_last
   );
endinterface

// File: rtl/matmult_seq_ctrl.sv
// rtl/matmult_seq_ctrl.sv - sequential NxN matrix multiply over one shared MAC with streamed results
module matmult_seq_ctrl #(
   parameter int N  = 2,
   parameter int DW = 16,
   parameter int AW = 32
) (
   input  logic                clk,
   input  logic                rst,
   matmult_seq_ctrl_if.slave   bus
);
   localparam int IW = $clog2(N*N);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, FINISH} state_t;

   state_t        state, state_nx;
   logic [DW-1:0] a_mem [N*N];
   logic [DW-1:0] b_mem [N*N];
   logic [AW-1:0] c_mem [N*N];
   logic [AW-1:0] acc;
   logic [CW-1:0] i, j, k;

   logic          i_last, j_last, k_last, mac_last;
   logic [IW-1:0] a_idx, b_idx, c_idx;
   logic [2*DW-1:0] prod;
   logic [AW-1:0] mac_sum;
   logic          load_ok, drain;

   assign i_last   = (i == CW'(N-1));
   assign j_last   = (j == CW'(N-1));
   assign k_last   = (k == CW'(N-1));
   assign mac_last = i_last && j_last && k_last;

   assign a_idx   = IW'(int'(i) * N + int'(k));
   assign b_idx   = IW'(int'(k) * N + int'(j));
   assign c_idx   = IW'(int'(i) * N + int'(j));
   assign prod    = {{DW{1'b0}}, a_mem[a_idx]} * {{DW{1'b0}}, b_mem[b_idx]};
   assign mac_sum = acc + AW'(prod);

   assign load_ok = (state == IDLE) && bus.load_en &&
                    ({1'b0, bus.load_addr} < (IW+1)'(N*N));
   assign drain   = (state == DRAIN);

   // i/j double as the drain cursor, so the beat index is the same C address used by the MAC.
   assign bus.res_valid = drain;
   assign bus.res_data  = drain ? c_mem[c_idx] : '0;
   assign bus.res_row   = drain ? i : '0;
   assign bus.res_col   = drain ? j : '0;
   assign bus.res_last  = drain && i_last && j_last;
   assign bus.busy      = (state == COMPUTE) || drain;
   assign bus.done      = (state == FINISH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = COMPUTE;
         COMPUTE: if (mac_last) state_nx = DRAIN;
         DRAIN:   if (bus.res_ready && bus.res_last) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int n = 0; n < N*N; n++) begin
            a_mem[n] <= '0;
            b_mem[n] <= '0;
            c_mem[n] <= '0;
         end
         acc <= '0;
         i   <= '0;
         j   <= '0;
         k   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load_ok) begin
                  if (bus.load_sel) b_mem[bus.load_addr] <= bus.load_data;
                  else              a_mem[bus.load_addr] <= bus.load_data;
               end
               if (bus.start) begin
                  acc <= '0;
                  i   <= '0;
                  j   <= '0;
                  k   <= '0;
               end
            end
            COMPUTE: begin
               if (k_last) begin
                  c_mem[c_idx] <= mac_sum;
                  acc <= '0;
                  k   <= '0;
                  if (j_last) begin
                     j <= '0;
                     i <= i_last ? '0 : i + CW'(1);
                  end else begin
                     j <= j + CW'(1);
                  end
               end else begin
                  acc <= mac_sum;
                  k   <= k + CW'(1);
               end
            end
            DRAIN: begin
               if (bus.res_ready) begin
                  if (j_last) begin
                     j <= '0;
                     i <= i_last ? '0 : i + CW'(1);
                  end else begin
                     j <= j + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_matmult_seq_ctrl.sv
// tb/tb_matmult_seq_ctrl.sv - scoreboard bench for matmult_seq_ctrl
module tb_matmult_seq_ctrl;
   localparam int N  = 2;
   localparam int DW = 16;
   localparam int AW = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   matmult_seq_ctrl_if #(.N(N), .DW(DW), .AW(AW)) bus ();

   matmult_seq_ctrl #(.N(N), .DW(DW), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [AW-1:0] data;
      int            row;
      int            col;
      logic          last;
   } beat_t;

   beat_t         sb[$];
   int            checks = 0;
   int            errors = 0;
   int            done_cnt = 0;
   int            beats = 0;
   logic [DW-1:0] ma [N*N];
   logic [DW-1:0] mb [N*N];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void push_expected();
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            beat_t         b;
            logic [AW-1:0] acc;
            logic [63:0]   p;
            acc = '0;
            for (int m = 0; m < N; m++) begin
               p   = 64'(ma[r*N+m]) * 64'(mb[m*N+c]);
               acc = acc + p[AW-1:0];
            end
            b.data = acc;
            b.row  = r;
            b.col  = c;
            b.last = (r == N-1) && (c == N-1);
            sb.push_back(b);
         end
      end
   endfunction

   // Beats are judged at the falling edge; a beat counts as taken when ready is also high.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.done) begin
            done_cnt++;
            check("done_busy", bus.busy, 0);
            check("done_valid", bus.res_valid, 0);
         end
         if (bus.res_valid) begin
            check("beats_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               check("res_data", bus.res_data, sb[0].data);
               check("res_row", bus.res_row, 64'(sb[0].row));
               check("res_col", bus.res_col, 64'(sb[0].col));
               check("res_last", bus.res_last, sb[0].last);
               if (bus.res_ready) begin
                  void'(sb.pop_front());
                  beats++;
               end
            end
         end
      end
   end

   task automatic load(input bit sel, input int addr, input logic [DW-1:0] d);
      bus.load_en   = 1'b1;
      bus.load_sel  = sel;
      bus.load_addr = 2'(addr);
      bus.load_data = d;
      @(posedge clk); #1;
      bus.load_en = 1'b0;
      if (sel) mb[addr] = d;
      else     ma[addr] = d;
   endtask

   task automatic load_ab(input logic [DW-1:0] a [N*N], input logic [DW-1:0] b [N*N]);
      for (int n = 0; n < N*N; n++) load(1'b0, n, a[n]);
      for (int n = 0; n < N*N; n++) load(1'b1, n, b[n]);
   endtask

   task automatic run(input bit stall, input bit inject, input bit same_edge);
      int edges, stall_cnt, d0, b0, t;
      if (same_edge) begin
         bus.load_en   = 1'b1;
         bus.load_sel  = 1'b0;
         bus.load_addr = '0;
         bus.load_data = 16'd10;
         ma[0] = 16'd10;
      end
      push_expected();
      d0 = done_cnt;
      b0 = beats;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      edges = 1;
      check("busy_after_start", bus.busy, 1);
      while (!bus.res_valid && edges < 40) begin
         if (inject && edges == 3) begin
            bus.start     = 1'b1;
            bus.load_en   = 1'b1;
            bus.load_sel  = 1'b0;
            bus.load_addr = '0;
            bus.load_data = 16'd9;
         end
         @(posedge clk); #1;
         edges++;
         bus.start   = 1'b0;
         bus.load_en = 1'b0;
      end
      check("latency", edges, 9);
      stall_cnt = 0;
      t = 0;
      while (done_cnt == d0 && t < 100) begin
         bus.res_ready = !(stall && (beats - b0) == 1 && stall_cnt < 3);
         if (!bus.res_ready) stall_cnt++;
         @(posedge clk); #1;
         t++;
      end
      bus.res_ready = 1'b1;
      check("done_seen", done_cnt - d0, 1);
      repeat (3) @(posedge clk);
      #1;
      check("done_once", done_cnt - d0, 1);
      check("beat_count", beats - b0, 4);
      check("busy_idle", bus.busy, 0);
      check("sb_empty", sb.size(), 0);
   endtask

   initial begin
      int d0;
      bus.load_en   = 1'b0;
      bus.load_sel  = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      bus.start     = 1'b0;
      bus.res_ready = 1'b1;
      for (int n = 0; n < N*N; n++) begin
         ma[n] = '0;
         mb[n] = '0;
      end

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_valid", bus.res_valid, 0);
      check("rst_last", bus.res_last, 0);
      check("rst_data", bus.res_data, 0);
      check("rst_row", bus.res_row, 0);
      check("rst_col", bus.res_col, 0);
      rst = 1'b1;
      @(posedge clk); #1;

      load_ab('{16'd1, 16'd2, 16'd3, 16'd4}, '{16'd5, 16'd6, 16'd7, 16'd8});
      run(1'b0, 1'b0, 1'b0);
      run(1'b1, 1'b0, 1'b0);
      run(1'b0, 1'b1, 1'b0);
      run(1'b0, 1'b0, 1'b0);

      load_ab('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
      run(1'b0, 1'b0, 1'b0);

      // Abort in the middle of COMPUTE; every store is cleared so the rerun yields zeros.
      load_ab('{16'd1, 16'd2, 16'd3, 16'd4}, '{16'd5, 16'd6, 16'd7, 16'd8});
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_valid", bus.res_valid, 0);
      check("abort_done", bus.done, 0);
      d0 = done_cnt;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - d0, 0);
      for (int n = 0; n < N*N; n++) begin
         ma[n] = '0;
         mb[n] = '0;
      end
      run(1'b0, 1'b0, 1'b0);

      load_ab('{16'd1, 16'd2, 16'd3, 16'd4}, '{16'd5, 16'd6, 16'd7, 16'd8});
      run(1'b0, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/matmult_seq_ctrl.md
Name: matmult_seq_ctrl

Overview:
Sequencer for the matrix-multiply datapath. It holds NxN operand matrices A and B that are loaded word-by-word, and time-shares a single multiply-accumulate unit to compute C = A x B over N^3 cycles. It then streams the N^2 results out row-major over a valid/ready handshake. It replaces a fully parallel multiplier array when area matters, and it is the block the accelerator top issues start/done commands to.

Parameters:
N, 2, matrix dimension (N >= 2).
DW, 16, operand width (unsigned).
AW, 32, accumulator/result width.
IW, $clog2(N*N), load address width (derived; not overridden).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
load_en  input  1  operand write strobe.
load_sel  input  1  0 = write A, 1 = write B.
load_addr  input  IW  element index = row*N + col.
load_data  input  DW  operand value.
start  input  1  begin a multiply.
busy  output  1  high from accepted start until final result handshake.
done  output  1  one-cycle pulse after the final result handshake.
res_valid  output  1  result beat valid.
res_ready  input  1  downstream accepts the beat.
res_data  output  AW  C[row][col].
res_row  output  $clog2(N)  row index of the beat.
res_col  output  $clog2(N)  column index of the beat.
res_last  output  1  high on the beat for C[N-1][N-1].

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; busy, done, res_valid, res_last = 0; res_data, res_row, res_col = 0; the A, B and C stores and the accumulator are cleared to 0. Asserting rst mid-operation aborts the operation, and no done pulse is produced.
- States: IDLE, COMPUTE, DRAIN, FINISH.
- IDLE:
  - A load_en at a clock edge writes load_data into A or B at load_addr. Out-of-range addresses (>= N*N) are ignored.
  - start sampled high moves the FSM to COMPUTE and clears i, j, k and acc to 0.
  - Load and start at the same edge: the write lands, and the computation uses the new value.
- COMPUTE, one MAC per cycle:
  - Each cycle: acc <= acc + A[i][k]*B[k][j].
  - When k == N-1, the cycle stores acc + product into C[i][j] and clears acc.
  - Index order: k innermost, then j, then i.
  - After the cycle with i = j = k = N-1, the FSM moves to DRAIN.
  - The phase lasts exactly N^3 cycles (8 for N=2).
- Arithmetic: unsigned. The product is 2*DW bits, zero-extended or truncated to AW. Accumulation wraps modulo 2^AW, with no saturation.
- DRAIN:
  - res_valid is high on the first cycle after the last COMPUTE edge. For N=2, that is 9 edges after the start edge.
  - Beats are presented in row-major order: C[0][0], C[0][1], ... C[N-1][N-1].
  - A beat transfers on an edge where res_valid and res_ready are both high, and the next beat appears in the following cycle.
  - While res_valid is high and res_ready is low, res_data, res_row, res_col and res_last hold stable.
  - res_valid stays high continuously from entry to DRAIN until the last handshake; there are no bubbles.
  - res_ready high before DRAIN has no effect.
- FINISH: entered after the last-beat handshake. In that cycle res_valid = 0, busy = 0 and done = 1, and the FSM returns to IDLE on the next edge. done is high for exactly one cycle.
- busy:
  - Goes high the cycle after the start edge.
  - Stays high through COMPUTE and DRAIN.
  - Is low in FINISH and IDLE.
- While busy:
  - start is ignored, with no queuing.
  - load_en is ignored, so A and B are unchanged.
- A and B persist after completion. A new start without reloading recomputes the same result.

Test Plan:
- Basic product: load A = [[1,2],[3,4]] and B = [[5,6],[7,8]], hold res_ready = 1, pulse start.
  - -> res_valid rises 9 edges after start.
  - -> Beats are 19, 22, 43, 50 with (row,col) = (0,0), (0,1), (1,0), (1,1).
  - -> res_last is high only on 50.
  - -> done pulses for 1 cycle after the last beat; busy then reads 0.
- Backpressure: same operands, res_ready low for 3 cycles while beat 22 is presented.
  - -> res_data holds 22 with (0,1) stable for those cycles.
  - -> The sequence completes with no loss or duplicates.
- Wrap: all A and B elements = 0xFFFF.
  - -> Each C = 2*0xFFFE0001 mod 2^32 = 0xFFFC0002; all four beats equal 0xFFFC0002.
- Ignored commands: during COMPUTE, pulse start and write A[0] = 9.
  - -> Results are still 19, 22, 43, 50; exactly one done.
  - -> A subsequent start with no reload yields 19, 22, 43, 50 again.
- Mid-run reset: assert rst low at COMPUTE cycle 4, then release.
  - -> busy, res_valid and done are 0 immediately; no done pulse.
  - -> A start with no reload yields four beats of 0.
- Same-edge load and start: with A = [[1,2],[3,4]] already loaded, write A[0] = 10 on the same edge as start.
  - -> The first result is 10*5 + 2*7 = 64, followed by 22*... i.e. the stream is 64, 76, 43, 50.
